// File: rtl/mealy_ctrl_pkg.sv
// Shared types and defaults for the Mealy sequence-detector controller.
package mealy_ctrl_pkg;

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  function automatic int unsigned len_w(input int unsigned pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  localparam int unsigned DefPattern = 0;
  localparam int unsigned DefLen     = 1;
  localparam bit          DefOverlap = 1'b1;
  localparam int unsigned DefThresh  = 0;
  localparam int unsigned DefWindow  = 0;

endpackage

// File: rtl/mealy_pat_match.sv
// Bit history, fill tracking and combinational pattern compare for the Mealy detector.
module mealy_pat_match
  import mealy_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = len_w(PAT_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             x_i,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic             overlap_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             y_o
);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] cand, mask;
  logic             fill_ok;

  // fill counts how many history bits are valid for the current compare
  always_comb begin
    cand    = {hist_q, x_i};
    mask    = ~({PAT_W{1'b1}} << len_i);
    fill_ok = (fill_q >= (len_i - LEN_W'(1)));
    y_o     = shift_en_i & fill_ok & (((cand ^ pattern_i) & mask) == '0);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en_i) begin
      hist_d = cand[PAT_W-2:0];
      if (y_o && !overlap_i) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(PAT_W)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/mealy_seq_ctrl.sv
// Run-time controller: config registers, detection window FSM, match counting and status pulses.
module mealy_seq_ctrl
  import mealy_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16,
  localparam int unsigned LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             x_valid,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] thr_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d, cnt_nxt;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d, win_nxt;
  logic             done_q, timeout_q, cfg_err_q;
  logic             armed, bit_en, start_go, cfg_fire, len_ok, match_inc, hit_thr, hit_win;

  assign armed     = (state_q == StArmed);
  assign cfg_ready = ~armed;
  assign busy      = armed;
  assign match_cnt = match_cnt_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cfg_err   = cfg_err_q;

  mealy_pat_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_pat_match (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .x_i        (x),
    .shift_en_i (bit_en),
    .clear_i    (start_go),
    .overlap_i  (ovl_q),
    .pattern_i  (pat_q),
    .len_i      (len_q),
    .y_o        (y)
  );

  // abort outranks a match, threshold outranks window exhaustion on the same bit
  always_comb begin
    bit_en    = armed & x_valid;
    start_go  = start & ~armed;
    cfg_fire  = cfg_valid & ~armed;
    len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    match_inc = y & ~abort;
    cnt_nxt   = (match_inc && !(&match_cnt_q)) ? match_cnt_q + CNT_W'(1) : match_cnt_q;
    win_nxt   = win_cnt_q + WIN_W'(1);
    hit_thr   = match_inc && (thr_q != '0) && (cnt_nxt == thr_q);
    hit_win   = bit_en && (win_q != '0) && (win_nxt == win_q);

    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    if (start_go) begin
      state_d     = StArmed;
      match_cnt_d = '0;
      win_cnt_d   = '0;
    end else if (armed) begin
      match_cnt_d = cnt_nxt;
      if (bit_en) win_cnt_d = win_nxt;
      if (abort || hit_thr || hit_win) state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pat_q       <= PAT_W'(DefPattern);
      len_q       <= LEN_W'(DefLen);
      ovl_q       <= DefOverlap;
      thr_q       <= CNT_W'(DefThresh);
      win_q       <= WIN_W'(DefWindow);
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      done_q      <= armed & ~abort & hit_thr;
      timeout_q   <= armed & ~abort & hit_win & ~hit_thr;
      cfg_err_q   <= cfg_fire & ~len_ok;
      if (cfg_fire && len_ok) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        thr_q <= cfg_thresh;
        win_q <= cfg_window;
      end
    end
  end

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Directed bench for mealy_seq_ctrl with hand-computed expectations.
module tb_mealy_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_overlap, start, abort, x, x_valid;
  logic [7:0]  cfg_pattern, cfg_thresh;
  logic [3:0]  cfg_len;
  logic [15:0] cfg_window;
  logic [1:0]  thr2;
  logic        cfg_ready, y, busy, done, timeout, cfg_err;
  logic [7:0]  match_cnt;
  logic        cfg_ready2, y2, busy2, done2, timeout2, cfg_err2;
  logic [1:0]  match_cnt2;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  assign thr2 = cfg_thresh[1:0];

  always #5 clk = ~clk;

  mealy_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_thresh(cfg_thresh), .cfg_window(cfg_window), .start(start), .abort(abort),
    .x(x), .x_valid(x_valid), .y(y), .match_cnt(match_cnt), .busy(busy), .done(done),
    .timeout(timeout), .cfg_err(cfg_err)
  );

  mealy_seq_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_thresh(thr2), .cfg_window(cfg_window), .start(start), .abort(abort),
    .x(x), .x_valid(x_valid), .y(y2), .match_cnt(match_cnt2), .busy(busy2), .done(done2),
    .timeout(timeout2), .cfg_err(cfg_err2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic arm(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic [7:0] thr, input logic [15:0] win);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    cfg_thresh = thr; cfg_window = win; start = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0; start = 1'b0;
    check_eq("arm_busy", busy, 1);
    check_eq("arm_cnt", match_cnt, 0);
  endtask

  task automatic put_bit(input logic b, input logic v, input logic exp_y, input string tag);
    x = b; x_valid = v; #1;
    check_eq(tag, y, exp_y);
    @(posedge clk); #1;
    x_valid = 1'b0;
  endtask

  // Index i holds bit i+1 of the stream; pulses are checked right after each bit's edge.
  task automatic run_stream(input logic [8:0] bits, input int n, input logic [8:0] exp_y,
                            input logic [8:0] exp_done, input logic [8:0] exp_to,
                            input string tag);
    for (int i = 0; i < n; i++) begin
      put_bit(bits[i], 1'b1, exp_y[i], $sformatf("%s_y%0d", tag, i + 1));
      check_eq($sformatf("%s_done%0d", tag, i + 1), done, exp_done[i]);
      check_eq($sformatf("%s_to%0d", tag, i + 1), timeout, exp_to[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_thresh = '0; cfg_window = '0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
    #12;
    check_eq("rst_ready", cfg_ready, 1);
    check_eq("rst_ready2", cfg_ready2, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cnt", match_cnt, 0);
    check_eq("rst_pulses", {done, timeout, cfg_err, y}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: overlapping 101, window 9
    arm(8'b101, 4'd3, 1'b1, 8'd0, 16'd9);
    run_stream(9'b101011101, 9, 9'b101000100, 9'b0, 9'b100000000, "t1");
    check_eq("t1_cnt", match_cnt, 3);
    check_eq("t1_busy", busy, 0);
    @(posedge clk); #1;
    check_eq("t1_to_gone", timeout, 0);

    // 2: non-overlapping
    arm(8'b101, 4'd3, 1'b0, 8'd0, 16'd9);
    run_stream(9'b101011101, 9, 9'b001000100, 9'b0, 9'b100000000, "t2");
    check_eq("t2_cnt", match_cnt, 2);

    // 3: threshold 2 ends the window after bit 7
    arm(8'b101, 4'd3, 1'b1, 8'd2, 16'd9);
    run_stream(9'b101011101, 9, 9'b001000100, 9'b001000000, 9'b0, "t3");
    check_eq("t3_cnt", match_cnt, 2);
    check_eq("t3_busy", busy, 0);

    // 4: threshold and window end on the same bit
    arm(8'b101, 4'd3, 1'b1, 8'd1, 16'd3);
    run_stream(9'b000000101, 3, 9'b000000100, 9'b000000100, 9'b0, "t4");
    check_eq("t4_cnt", match_cnt, 1);

    // 4b: abort on bit 2
    arm(8'b101, 4'd3, 1'b1, 8'd1, 16'd3);
    put_bit(1'b1, 1'b1, 1'b0, "ab_y1");
    abort = 1'b1;
    put_bit(1'b0, 1'b1, 1'b0, "ab_y2");
    abort = 1'b0;
    check_eq("ab_busy", busy, 0);
    check_eq("ab_pulses", {done, timeout}, 0);
    check_eq("ab_cnt", match_cnt, 0);

    // 4c: abort beats a completing match
    arm(8'b101, 4'd3, 1'b1, 8'd0, 16'd0);
    put_bit(1'b1, 1'b1, 1'b0, "abp_y1");
    put_bit(1'b0, 1'b1, 1'b0, "abp_y2");
    abort = 1'b1;
    put_bit(1'b1, 1'b1, 1'b1, "abp_y3");
    abort = 1'b0;
    check_eq("abp_cnt", match_cnt, 0);
    check_eq("abp_busy", busy, 0);
    check_eq("abp_done", done, 0);

    // 5: illegal lengths rejected, old config (101, len 3, no thresh/window) stays
    for (int k = 0; k < 2; k++) begin
      cfg_valid = 1'b1; cfg_pattern = 8'hff; cfg_len = (k == 0) ? 4'd0 : 4'd9;
      cfg_thresh = 8'd5; cfg_window = 16'd2; cfg_overlap = 1'b0;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      check_eq($sformatf("err_pulse%0d", k), cfg_err, 1);
      @(posedge clk); #1;
      check_eq($sformatf("err_gone%0d", k), cfg_err, 0);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("t5_busy", busy, 1);
    run_stream(9'b000000101, 3, 9'b000000100, 9'b0, 9'b0, "t5");
    cfg_valid = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd1; #1;
    check_eq("busy_ready", cfg_ready, 0);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check_eq("busy_noerr", cfg_err, 0);
    put_bit(1'b0, 1'b1, 1'b0, "nocfg_y0");
    put_bit(1'b1, 1'b1, 1'b1, "nocfg_y1");
    check_eq("t5_cnt", match_cnt, 2);
    x = 1'b1; x_valid = 1'b1;
    rst_n = 1'b0; #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_cnt", match_cnt, 0);
    check_eq("mid_rst_y", y, 0);
    check_eq("mid_rst_ready", cfg_ready, 1);
    check_eq("mid_rst_pulses", {done, timeout, cfg_err}, 0);
    x_valid = 1'b0; #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Defaults after reset: len 1, pattern 0
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    put_bit(1'b0, 1'b1, 1'b1, "def_y0");
    put_bit(1'b1, 1'b1, 1'b0, "def_y1");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("def_cnt", match_cnt, 1);
    check_eq("def_busy", busy, 0);

    // 6: saturation on the 2-bit counter; invalid bits do not use window budget
    arm(8'h01, 4'd1, 1'b1, 8'd0, 16'd8);
    run_stream(9'b000111111, 6, 9'b000111111, 9'b0, 9'b0, "t6");
    check_eq("sat_cnt2", match_cnt2, 3);
    check_eq("sat_cnt", match_cnt, 6);
    put_bit(1'b1, 1'b0, 1'b0, "gap_y1");
    put_bit(1'b1, 1'b0, 1'b0, "gap_y2");
    check_eq("gap_busy", busy, 1);
    check_eq("gap_to", timeout, 0);
    put_bit(1'b1, 1'b1, 1'b1, "t6_y7");
    check_eq("t6_to7", timeout, 0);
    check_eq("t6_busy7", busy2, 1);
    put_bit(1'b1, 1'b1, 1'b1, "t6_y8");
    check_eq("t6_to8", timeout, 1);
    check_eq("t6_to8_2", timeout2, 1);
    check_eq("t6_cnt2", match_cnt2, 3);
    check_eq("t6_busy8", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
